uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the UART receiver. It detects each completed-byte strobe, captures the received byte into a first-word-fall-through FIFO, and presents bytes to the consumer over a valid/ready interface. It provides full and empty status, an occupancy count, and a sticky overflow flag so that lost bytes are visible to higher layers.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_fifo_mem.sv | 25 ++
 rtl/uart_rx_fifo.sv | 75 +++++++
 tb/tb_uart_rx_fifo.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Constants shared by the UART receiver, transmitter and receive buffer.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;
  localparam int UART_CLK_HZ        = 50_000_000;
  localparam int UART_BAUD          = 115_200;
  localparam int UART_CLKS_PER_BIT  = UART_CLK_HZ / UART_BAUD;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int  DATA_W = UART_DATA_W,
  parameter int  DEPTH  = UART_RX_FIFO_DEPTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer: one push per rx_done rising edge,
// valid/ready drain, occupancy count and sticky overflow flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int  DATA_W = UART_DATA_W,
  parameter int  DEPTH  = UART_RX_FIFO_DEPTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] rx_dat,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic          rx_done_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          accept;
  logic          drop;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign rd_valid = !empty;

  assign push   = rx_done & ~rx_done_q;
  assign pop    = rd_valid & rd_ready;
  // A pop on a full FIFO frees the slot the same-cycle push writes into.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (rx_dat),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      // Starts high so a strobe held through reset is not seen as a new edge.
      rx_done_q <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      if (accept && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !accept) count <= count - (AW+1)'(1);
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: inputs change and outputs are sampled on
// the falling edge, so every rising edge sees settled stimulus.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_done;
  logic [7:0] rx_dat;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       ovf_clr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .rx_done  (rx_done),
    .rx_dat   (rx_dat),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  // One-cycle strobe followed by one low cycle; called and returns on a falling edge.
  task automatic strobe(input logic [7:0] d);
    rx_dat  = d;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (count !== 5'd0)   begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0)    begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_long_pulse;
    rx_dat  = 8'hA5;
    rx_done = 1'b1;
    @(negedge clk);
    checks++; if (count !== 5'd1)    begin errors++; $display("FAIL long_count1 got=%0d exp=1", count); end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL long_valid got=%b exp=1", rd_valid); end
    checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL long_data got=%h exp=a5", rd_data); end
    repeat (199) @(negedge clk);
    checks++; if (count !== 5'd1)    begin errors++; $display("FAIL long_count_held got=%0d exp=1", count); end
    rx_done  = 1'b0;
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL long_empty got=%b exp=1", empty); end
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 16; i++) strobe(8'(i + 1));
    checks++; if (full !== 1'b1)   begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count got=%0d exp=16", count); end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i + 1)) begin
        errors++; $display("FAIL drain_data idx=%0d got=%h valid=%b exp=%h", i, rd_data, rd_valid, 8'(i + 1));
      end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 16; i++) strobe(8'(i + 1));
    strobe(8'hFF);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    checks++; if (count !== 5'd16)   begin errors++; $display("FAIL ovf_count got=%0d exp=16", count); end
    // drop and clear together: set must win
    rx_dat  = 8'hFE;
    rx_done = 1'b1;
    ovf_clr = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i + 1)) begin
        errors++; $display("FAIL ovf_drain idx=%0d got=%h exp=%h", i, rd_data, 8'(i + 1));
      end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_full_push_pop;
    for (int i = 0; i < 16; i++) strobe(8'(8'h20 + i));
    rx_dat   = 8'h77;
    rx_done  = 1'b1;
    rd_ready = 1'b1;
    @(negedge clk);
    rx_done  = 1'b0;
    rd_ready = 1'b0;
    checks++; if (count !== 5'd16)   begin errors++; $display("FAIL fpp_count got=%0d exp=16", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got=%b exp=0", overflow); end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_d;
      exp_d = (i < 15) ? 8'(8'h21 + i) : 8'h77;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_d) begin
        errors++; $display("FAIL fpp_drain idx=%0d got=%h exp=%h", i, rd_data, exp_d);
      end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fpp_empty got=%b exp=1", empty); end
  endtask

  task automatic test_reset_strobe;
    strobe(8'h11);
    strobe(8'h22);
    rx_done = 1'b1;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_strobe_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_strobe_empty got=%b exp=1", empty); end
    rx_done = 1'b0;
    @(negedge clk);
    strobe(8'h5C);
    checks++; if (count !== 5'd1)    begin errors++; $display("FAIL rst_fresh_count got=%0d exp=1", count); end
    checks++; if (rd_data !== 8'h5C) begin errors++; $display("FAIL rst_fresh_data got=%h exp=5c", rd_data); end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic test_back_to_back_wrap;
    logic [7:0] q[$];
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    logic do_pop;
    while ((sent < 40 || q.size() != 0) && cyc < 2000) begin
      checks++;
      if (rd_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL wrap_valid cyc=%0d got=%b exp=%b", cyc, rd_valid, q.size() != 0);
      end
      checks++;
      if (count !== 5'(q.size())) begin
        errors++; $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", cyc, count, q.size());
      end
      if (q.size() != 0) begin
        checks++;
        if (rd_data !== q[0]) begin
          errors++; $display("FAIL wrap_data cyc=%0d got=%h exp=%h", cyc, rd_data, q[0]);
        end
      end
      rd_ready = 1'($urandom_range(0, 1));
      if (rx_done) rx_done = 1'b0;
      else if (sent < 40 && q.size() < 12) begin
        rx_dat  = 8'(8'h40 + sent);
        rx_done = 1'b1;
        sent++;
      end
      do_pop = rd_ready && (q.size() != 0);
      if (rx_done) q.push_back(rx_dat);
      if (do_pop) begin
        void'(q.pop_front());
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    rx_done  = 1'b0;
    rd_ready = 1'b0;
    checks++; if (cyc >= 2000) begin errors++; $display("FAIL wrap_timeout got=%0d cycles exp<2000", cyc); end
    checks++; if (got !== 40)  begin errors++; $display("FAIL wrap_total got=%0d exp=40", got); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  initial begin
    rst      = 1'b1;
    rx_done  = 1'b0;
    rx_dat   = 8'h00;
    rd_ready = 1'b0;
    ovf_clr  = 1'b0;
    @(negedge clk);
    test_reset();
    test_long_pulse();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_reset_strobe();
    test_back_to_back_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
